sdram_port_arbiter: RTL

- Two-requester arbiter that shares one SDRAM controller port between two caches, typically the instruction cache and the data cache.
- Each cache port uses the native cache memory protocol:
  - req pulse or level, with wren, address and write data;
  - then a ready-high burst with a word offset (critical word first);
  - completion is marked by ready falling.
- The block latches requests, picks a winner, replays the request downstream, and routes the burst back to the granted port only.

---
 rtl/sdram_port_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between two cache ports: latches requests,
// arbitrates, replays the winner's request downstream and steers the burst back.
module sdram_port_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_wren,
  input  logic [AW-1:0] p0_address,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic [1:0]    p0_offset,
  output logic          p0_ready,
  input  logic          p1_req,
  input  logic          p1_wren,
  input  logic [AW-1:0] p1_address,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic [1:0]    p1_offset,
  output logic          p1_ready,
  output logic          sd_req,
  output logic          sd_wren,
  output logic [AW-1:0] sd_address,
  output logic [DW-1:0] sd_wdata,
  input  logic [DW-1:0] sd_rdata,
  input  logic [1:0]    sd_offset,
  input  logic          sd_ready,
  output logic          grant,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, XFER} state_e;

  state_e        state_q;
  logic          pend0_q, pend1_q;
  logic          hold_wren0_q, hold_wren1_q;
  logic [AW-1:0] hold_addr0_q, hold_addr1_q;
  logic          rr_q, grant_q, busy_q;
  logic          sd_req_q, sd_wren_q;
  logic [AW-1:0] sd_address_q;

  logic active_c, burst_c, done_c, cap0_c, cap1_c, win_d;

  assign active_c = (state_q != IDLE);
  assign burst_c  = (state_q == WAIT) || (state_q == XFER);
  assign done_c   = (state_q == XFER) && !sd_ready;
  // The active grantee cannot re-arm, so a level request held until done is one transaction.
  assign cap0_c   = p0_req && !pend0_q && !(active_c && !grant_q);
  assign cap1_c   = p1_req && !pend1_q && !(active_c && grant_q);

  // Winner selection from the pending flags as they stand in IDLE.
  always_comb begin
    win_d = rr_q;
    if (pend0_q && !pend1_q) begin
      win_d = 1'b0;
    end else if (!pend0_q && pend1_q) begin
      win_d = 1'b1;
    end else if (FIXED_PRIO) begin
      win_d = 1'b0;
    end
  end

  // Request capture and per-port hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      hold_wren0_q <= 1'b0;
      hold_wren1_q <= 1'b0;
      hold_addr0_q <= '0;
      hold_addr1_q <= '0;
    end else begin
      if (cap0_c) begin
        pend0_q      <= 1'b1;
        hold_wren0_q <= p0_wren;
        hold_addr0_q <= p0_address;
      end else if (done_c && !grant_q) begin
        pend0_q <= 1'b0;
      end
      if (cap1_c) begin
        pend1_q      <= 1'b1;
        hold_wren1_q <= p1_wren;
        hold_addr1_q <= p1_address;
      end else if (done_c && grant_q) begin
        pend1_q <= 1'b0;
      end
    end
  end

  // Arbitration FSM with registered downstream request, grant and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      sd_req_q     <= 1'b0;
      sd_wren_q    <= 1'b0;
      sd_address_q <= '0;
    end else begin
      sd_req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend0_q || pend1_q) begin
            grant_q      <= win_d;
            sd_req_q     <= 1'b1;
            sd_wren_q    <= win_d ? hold_wren1_q : hold_wren0_q;
            sd_address_q <= win_d ? hold_addr1_q : hold_addr0_q;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (sd_ready) begin
            state_q <= XFER;
          end
        end
        XFER: begin
          if (!sd_ready) begin
            rr_q    <= ~grant_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Burst steering is combinational so ready falls in the same cycle as sd_ready.
  assign p0_ready   = burst_c && !grant_q && sd_ready;
  assign p1_ready   = burst_c && grant_q && sd_ready;
  assign p0_rdata   = sd_rdata;
  assign p1_rdata   = sd_rdata;
  assign p0_offset  = sd_offset;
  assign p1_offset  = sd_offset;
  assign sd_wdata   = grant_q ? p1_wdata : p0_wdata;

  assign sd_req     = sd_req_q;
  assign sd_wren    = sd_wren_q;
  assign sd_address = sd_address_q;
  assign grant      = grant_q;
  assign busy       = busy_q;

endmodule
